// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: folds one DATA_W-bit word per cycle into a parametrised CRC
// and presents one finalised result per frame on a valid/ready output.
module crc_stream_engine #(
    parameter int          CRC_W       = 32,
    parameter logic [63:0] POLY        = 64'h0000_0000_04C1_1DB7,
    parameter logic [63:0] INIT        = 64'h0000_0000_FFFF_FFFF,
    parameter logic [63:0] XOR_OUT     = 64'h0000_0000_FFFF_FFFF,
    parameter bit          REFLECT_IN  = 1'b1,
    parameter bit          REFLECT_OUT = 1'b1,
    parameter int          DATA_W      = 32,
    localparam int         LANES       = DATA_W / 8,
    localparam int         NB_W        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [NB_W-1:0]   in_nbytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic              busy
);

    localparam logic [CRC_W-1:0] POLY_T = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_T = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_T  = XOR_OUT[CRC_W-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   seed;
    logic [CRC_W-1:0]   crc_next;
    logic [CRC_W-1:0]   crc_final;
    logic [LANES-1:0]   lane_en;
    logic               accept;

    // Non-reflected shift register; REFLECT_IN only changes the order bits are fed in.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] seed_in,
                                              input logic [DATA_W-1:0] data,
                                              input logic [LANES-1:0]  en);
        logic [CRC_W-1:0] c;
        logic             din;
        logic             fb;
        c = seed_in;
        for (int k = 0; k < LANES; k++) begin
            if (en[k]) begin
                for (int b = 0; b < 8; b++) begin
                    din = REFLECT_IN ? data[8*k + b] : data[8*k + 7 - b];
                    fb  = c[CRC_W-1] ^ din;
                    c   = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_T : '0);
                end
            end
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] reverse(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    assign in_ready  = (state != DONE) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == ACCUM);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        lane_en = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_en[k] = !in_last || (in_nbytes == '0) || (k < int'(in_nbytes));
        end
        seed      = (state == ACCUM) ? crc_q : INIT_T;
        crc_next  = fold(seed, in_data, lane_en);
        crc_final = (REFLECT_OUT ? reverse(crc_next) : crc_next) ^ XOR_T;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = in_last ? DONE : ACCUM;
            end
            ACCUM: begin
                if (accept && in_last) state_next = DONE;
            end
            DONE: begin
                // A word accepted while draining opens the next frame without a bubble.
                if (out_ready) state_next = accept ? (in_last ? DONE : ACCUM) : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            crc_q   <= INIT_T;
            out_crc <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                crc_q <= crc_next;
                if (in_last) out_crc <= crc_final;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench: CRC-32 defaults, CRC-32/MPEG-2 and CRC-16/CCITT-FALSE instances,
// table-driven frames plus hand-written back-pressure, reset and gap sequences.
module tb_crc_stream_engine;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_nbytes;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [31:0] a_out_crc;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [31:0] b_out_crc;

    logic        c_in_valid, c_in_last, c_out_ready;
    logic [7:0]  c_in_data;
    logic [0:0]  c_in_nbytes;
    logic        c_in_ready, c_out_valid, c_busy;
    logic [15:0] c_out_crc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  nb;
        logic [31:0] exp_crc;
        logic        chk_b;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[10];

    crc_stream_engine dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_crc(a_out_crc), .busy(a_busy)
    );

    crc_stream_engine #(
        .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .XOR_OUT(64'h0)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_crc(b_out_crc), .busy(b_busy)
    );

    crc_stream_engine #(
        .CRC_W(16), .POLY(64'h1021), .INIT(64'hFFFF), .XOR_OUT(64'h0),
        .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .DATA_W(8)
    ) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .in_nbytes(c_in_nbytes),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_crc(c_out_crc), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one word and return #1 after the edge that accepted it.
    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] nb);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        in_nbytes = nb;
        #1;
        while (!a_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!a_in_ready) check("in_ready_wait", {63'd0, a_in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_t1();
        send(32'h34333231, 1'b0, 2'd0);
        send(32'h38373635, 1'b0, 2'd0);
        send(32'h00000039, 1'b1, 2'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h34333231, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{32'h38373635, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[2] = '{32'h00000039, 1'b1, 2'd1, 32'hCBF43926, 1'b1, 32'h0376E6E7};
        vecs[3] = '{32'h34333231, 1'b1, 2'd0, 32'h9BE3E0A3, 1'b0, 32'h0};
        vecs[4] = '{32'h00000061, 1'b1, 2'd1, 32'hE8B7BE43, 1'b0, 32'h0};
        vecs[5] = '{32'h00636261, 1'b1, 2'd3, 32'h352441C2, 1'b0, 32'h0};
        vecs[6] = '{32'hFFFFFF61, 1'b1, 2'd1, 32'hE8B7BE43, 1'b0, 32'h0};
        vecs[7] = '{32'h34333231, 1'b0, 2'd2, 32'h0,        1'b0, 32'h0};
        vecs[8] = '{32'h38373635, 1'b0, 2'd3, 32'h0,        1'b0, 32'h0};
        vecs[9] = '{32'hAABBCC39, 1'b1, 2'd1, 32'hCBF43926, 1'b1, 32'h0376E6E7};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0; out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_in_nbytes = '0; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", {63'd0, a_out_valid}, 64'd0);
        check("reset_busy",      {63'd0, a_busy},      64'd0);
        check("reset_out_crc",   {32'd0, a_out_crc},   64'd0);
        check("reset_in_ready",  {63'd0, a_in_ready},  64'd1);

        // Table: T1 plus further frames, back-to-back with no idle cycle between frames.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].data, vecs[i].last, vecs[i].nb);
            if (vecs[i].last) begin
                check($sformatf("vec%0d_out_valid", i), {63'd0, a_out_valid}, 64'd1);
                check($sformatf("vec%0d_busy", i),      {63'd0, a_busy},      64'd0);
                check($sformatf("vec%0d_out_crc", i),   {32'd0, a_out_crc},   {32'd0, vecs[i].exp_crc});
                if (vecs[i].chk_b)
                    check($sformatf("vec%0d_mpeg2_crc", i), {32'd0, b_out_crc}, {32'd0, vecs[i].exp_b});
            end else begin
                check($sformatf("vec%0d_busy", i),      {63'd0, a_busy},      64'd1);
                check($sformatf("vec%0d_out_valid", i), {63'd0, a_out_valid}, 64'd0);
            end
        end
        @(posedge clk); #1;
        check("drain_to_idle", {63'd0, a_out_valid}, 64'd0);

        // T3: CRC-16/CCITT-FALSE, one byte per cycle.
        for (int i = 0; i < 9; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = 8'(8'h31 + i);
            c_in_last  = (i == 8);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        check("crc16_out_valid", {63'd0, c_out_valid}, 64'd1);
        check("crc16_out_crc",   {48'd0, c_out_crc},   64'h29B1);

        // T4: hold the result under back-pressure, then drain with a single-word frame.
        out_ready = 1'b0;
        send_t1();
        check("t4_out_valid", {63'd0, a_out_valid}, 64'd1);
        in_valid = 1'b1; in_data = 32'h34333231; in_last = 1'b1; in_nbytes = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("t4_hold%0d_valid", i), {63'd0, a_out_valid}, 64'd1);
            check($sformatf("t4_hold%0d_crc", i),   {32'd0, a_out_crc},   64'hCBF43926);
            check($sformatf("t4_hold%0d_ready", i), {63'd0, a_in_ready},  64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("t4_ready_release", {63'd0, a_in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t4_next_valid", {63'd0, a_out_valid}, 64'd1);
        check("t4_next_crc",   {32'd0, a_out_crc},   64'h9BE3E0A3);

        // T5: reset mid-frame discards the partial CRC.
        send(32'h34333231, 1'b0, 2'd0);
        check("t5_busy_before", {63'd0, a_busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_busy_after",  {63'd0, a_busy},      64'd0);
        check("t5_valid_after", {63'd0, a_out_valid}, 64'd0);
        check("t5_crc_after",   {32'd0, a_out_crc},   64'd0);
        send_t1();
        check("t5_replay_crc", {32'd0, a_out_crc}, 64'hCBF43926);

        // T6: random idle gaps inside the frame.
        @(posedge clk); #1;
        check("t6_busy_idle", {63'd0, a_busy}, 64'd0);
        for (int w = 0; w < 3; w++) begin
            if (w > 0) begin
                int gap;
                gap = int'($urandom_range(1, 3));
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    check($sformatf("t6_gap_busy_w%0d_%0d", w, g),  {63'd0, a_busy},      64'd1);
                    check($sformatf("t6_gap_valid_w%0d_%0d", w, g), {63'd0, a_out_valid}, 64'd0);
                end
            end
            case (w)
                0:       send(32'h34333231, 1'b0, 2'd0);
                1:       send(32'h38373635, 1'b0, 2'd0);
                default: send(32'h00000039, 1'b1, 2'd1);
            endcase
        end
        check("t6_out_valid", {63'd0, a_out_valid}, 64'd1);
        check("t6_busy_done", {63'd0, a_busy},      64'd0);
        check("t6_out_crc",   {32'd0, a_out_crc},   64'hCBF43926);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
